// File: rtl/rtp_collect_pkg.sv
// Shared types and constants for the ray-traversal hit collector.
// Holds the record widths, the "no hit yet" entry encoding, the FSM state
// type and the payload structs used between the collector and its RAM.
package rtp_collect_pkg;

   localparam int unsigned RAY_ID_W = 10;
   localparam int unsigned HIT_W    = 32;
   localparam int unsigned TRI_W    = 32;
   localparam int unsigned NUM_RAYS = 2 ** RAY_ID_W;
   localparam int unsigned CNT_W    = RAY_ID_W + 1;
   localparam int unsigned ENT_W    = HIT_W + TRI_W;

   // Empty entry: +infinity distance, all-ones triangle index
   localparam logic [HIT_W-1:0] HIT_T_INF = 32'h7F80_0000;
   localparam logic [TRI_W-1:0] TRI_NONE  = '1;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [RAY_ID_W-1:0] ray_id;
      logic [HIT_W-1:0]    hit_t;
      logic [TRI_W-1:0]    tri_idx;
   } hit_rec_t;

   typedef struct packed {
      logic [HIT_W-1:0] hit_t;
      logic [TRI_W-1:0] tri_idx;
   } res_ent_t;

   // A hit distance is usable only if positive and finite (not inf/NaN)
   function automatic logic hit_t_usable(input logic [HIT_W-1:0] t);
      return !t[HIT_W-1] && (t[HIT_W-2 -: 8] != 8'hFF);
   endfunction

endpackage

// File: rtl/rtp_result_ram.sv
// Per-ray closest-hit storage: simple dual-port RAM, one write and one
// synchronous read port with one cycle of read latency.
// Ports:
//   clock        rising-edge clock
//   we/waddr/wdata   write port
//   re/raddr     read request; rdata updates the cycle after re
//   rdata        registered read data (holds when re is low)
module rtp_result_ram
   import rtp_collect_pkg::*;
(
   input  logic                clock,
   input  logic                we,
   input  logic [RAY_ID_W-1:0] waddr,
   input  logic [ENT_W-1:0]    wdata,
   input  logic                re,
   input  logic [RAY_ID_W-1:0] raddr,
   output logic [ENT_W-1:0]    rdata
);

   logic [ENT_W-1:0] mem [NUM_RAYS];

   // Read-during-write to the same address returns the old contents
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/rtp_hit_collector.sv
// Closest-hit collector behind the ray-traversal core.
// Clears the result RAM after reset, then folds incoming hit records into a
// per-ray minimum through a 2-stage read/compare/write pipeline, counts
// retired rays and raises all_done once traversal has finished and the
// pipeline has drained. Results are read back through rd_* in DONE.
// Ports:
//   clock, reset          clock, asynchronous active-low reset
//   hit_valid/hit_ready   hit record handshake (ray_id, hit_t, hit_tri)
//   ray_done_valid        one pulse per finished ray
//   rtp_finish            traversal core finished (level)
//   rd_en/rd_addr         readout request, honoured only in DONE
//   rd_valid/rd_hit_t/rd_tri  readout data, one cycle after rd_en
//   rays_retired          saturating count of ray_done pulses
//   all_done              sticky completion flag
//   cycle_count           cycles spent in RUN/DRAIN
module rtp_hit_collector
   import rtp_collect_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                hit_valid,
   output logic                hit_ready,
   input  logic [RAY_ID_W-1:0] hit_ray_id,
   input  logic [HIT_W-1:0]    hit_t,
   input  logic [TRI_W-1:0]    hit_tri,
   input  logic                ray_done_valid,
   input  logic                rtp_finish,
   input  logic                rd_en,
   input  logic [RAY_ID_W-1:0] rd_addr,
   output logic                rd_valid,
   output logic [HIT_W-1:0]    rd_hit_t,
   output logic [TRI_W-1:0]    rd_tri,
   output logic [CNT_W-1:0]    rays_retired,
   output logic                all_done,
   output logic [63:0]         cycle_count
);

   localparam logic [RAY_ID_W-1:0] LAST_ADDR  = RAY_ID_W'(NUM_RAYS - 1);
   localparam logic [CNT_W-1:0]    RETIRE_MAX = CNT_W'(NUM_RAYS);

   state_t              state_q, state_d;
   logic [RAY_ID_W-1:0] clear_addr_q;

   logic     accept_c;
   logic     s0_valid_q, s1_valid_q;
   hit_rec_t s0_q, s1_q;
   logic     s1_fwd_q;
   res_ent_t s1_fwd_ent_q;
   logic     fwd_hit_c;
   logic     s1_we_c;
   res_ent_t stored_c;

   logic                ram_we_c, ram_re_c;
   logic [RAY_ID_W-1:0] ram_waddr_c, ram_raddr_c;
   res_ent_t            ram_wdata_c, ram_rdata_c;

   logic     rd_fire_c;
   res_ent_t rd_hold_q;

   // State register, clear address, and registered hit_ready/all_done
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= CLEAR;
         clear_addr_q <= '0;
         hit_ready    <= 1'b0;
         all_done     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) begin
            clear_addr_q <= clear_addr_q + RAY_ID_W'(1);
         end
         hit_ready <= (state_d == RUN);
         all_done  <= (state_d == DONE);
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR:   if (clear_addr_q == LAST_ADDR) state_d = RUN;
         RUN:     if (rtp_finish) state_d = DRAIN;
         DRAIN:   if (!s0_valid_q && !s1_valid_q) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = CLEAR;
      endcase
   end

   assign accept_c = hit_valid & hit_ready;

   // S1 compares against forwarded data when the previous hit to this ray
   // was written in the same cycle this hit's RAM read was issued.
   assign stored_c  = s1_fwd_q ? s1_fwd_ent_q : ram_rdata_c;
   assign s1_we_c   = s1_valid_q & hit_t_usable(s1_q.hit_t) &
                      (s1_q.hit_t[HIT_W-2:0] < stored_c.hit_t[HIT_W-2:0]);
   assign fwd_hit_c = s0_valid_q & s1_we_c & (s0_q.ray_id == s1_q.ray_id);

   // Pipeline valid bits and forwarding flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s0_valid_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_fwd_q   <= 1'b0;
      end else begin
         s0_valid_q <= accept_c;
         s1_valid_q <= s0_valid_q;
         s1_fwd_q   <= fwd_hit_c;
      end
   end

   // Pipeline payload
   always_ff @(posedge clock) begin
      if (accept_c) begin
         s0_q.ray_id  <= hit_ray_id;
         s0_q.hit_t   <= hit_t;
         s0_q.tri_idx <= hit_tri;
      end
      if (s0_valid_q) begin
         s1_q <= s0_q;
      end
      s1_fwd_ent_q.hit_t   <= s1_q.hit_t;
      s1_fwd_ent_q.tri_idx <= s1_q.tri_idx;
   end

   // RAM write port: initialisation sweep in CLEAR, pipeline updates otherwise
   always_comb begin
      ram_we_c            = s1_we_c;
      ram_waddr_c         = s1_q.ray_id;
      ram_wdata_c.hit_t   = s1_q.hit_t;
      ram_wdata_c.tri_idx = s1_q.tri_idx;
      if (state_q == CLEAR) begin
         ram_we_c            = 1'b1;
         ram_waddr_c         = clear_addr_q;
         ram_wdata_c.hit_t   = HIT_T_INF;
         ram_wdata_c.tri_idx = TRI_NONE;
      end
   end

   // RAM read port: pipeline lookups until DONE, bench readout afterwards
   assign rd_fire_c   = rd_en & (state_q == DONE);
   assign ram_re_c    = s0_valid_q | rd_fire_c;
   assign ram_raddr_c = (state_q == DONE) ? rd_addr : s0_q.ray_id;

   rtp_result_ram u_ram (
      .clock (clock),
      .we    (ram_we_c),
      .waddr (ram_waddr_c),
      .wdata (ram_wdata_c),
      .re    (ram_re_c),
      .raddr (ram_raddr_c),
      .rdata (ram_rdata_c)
   );

   // Readout: RAM output register is presented while rd_valid, then held
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_valid  <= 1'b0;
         rd_hold_q <= '0;
      end else begin
         rd_valid <= rd_fire_c;
         if (rd_valid) begin
            rd_hold_q <= ram_rdata_c;
         end
      end
   end

   assign rd_hit_t = rd_valid ? ram_rdata_c.hit_t   : rd_hold_q.hit_t;
   assign rd_tri   = rd_valid ? ram_rdata_c.tri_idx : rd_hold_q.tri_idx;

   // Retired-ray and active-cycle counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rays_retired <= '0;
         cycle_count  <= '0;
      end else begin
         if (ray_done_valid && (state_q != CLEAR) && (rays_retired != RETIRE_MAX)) begin
            rays_retired <= rays_retired + CNT_W'(1);
         end
         if ((state_q == RUN) || (state_q == DRAIN)) begin
            cycle_count <= cycle_count + 64'd1;
         end
      end
   end

endmodule
